// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package dmem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {IDLE, RD_WAIT} arb_state_t;

  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-response tracker: a READ_LAT-deep shift register of {valid, owner}
// that raises the owning port's rvalid exactly READ_LAT cycles after a read grant.
module dmem_rd_pipe
  import dmem_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   issue,
  input  owner_t owner,
  output logic   cpu_rvalid,
  output logic   dbg_rvalid
);

  logic [READ_LAT-1:0] vld_p;
  owner_t              own_p [READ_LAT];

  // Stage 0 captures the grant; each later stage delays it one cycle. Reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Owner tag travels alongside the valid bit; it is only meaningful where valid is set.
  always_ff @(posedge clk) begin
    own_p[0] <= owner;
    for (int i = 1; i < READ_LAT; i++) own_p[i] <= own_p[i-1];
  end

  // Last stage: response cycle
  assign cpu_rvalid = vld_p[READ_LAT-1] && (own_p[READ_LAT-1] == OWN_CPU);
  assign dbg_rvalid = vld_p[READ_LAT-1] && (own_p[READ_LAT-1] == OWN_DBG);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the CPU load/store path and the debug port.
// CPU wins ties unless DBG has been denied STARVE_LIMIT cycles in a row; grants
// pause while a multi-cycle read is outstanding.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_nxt;
  logic [STV_W-1:0] starve_cnt, starve_nxt;
  owner_t           owner, owner_nxt;
  logic             rd_issue;
  owner_t           rd_own;

  // Control registers: FSM state, read-latency countdown, DBG starvation count, read owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner      <= OWN_CPU;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_nxt;
      starve_cnt <= starve_nxt;
      owner      <= owner_nxt;
    end
  end

  // Grant selection, RAM-side mux, read sequencing and starvation bookkeeping.
  always_comb begin
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    state_nxt  = state;
    lat_nxt    = lat_cnt;
    owner_nxt  = owner;
    starve_nxt = starve_cnt;

    case (state)
      IDLE: begin
        // Grants are held off while reset is asserted so no RAM write slips through.
        if (!rst) begin
          if (dbg_req && (!cpu_req || starve_cnt == STV_W'(STARVE_LIMIT))) dbg_gnt = 1'b1;
          else if (cpu_req)                                                cpu_gnt = 1'b1;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LAT_W'(1)) begin
          state_nxt = IDLE;
          lat_nxt   = '0;
        end else begin
          lat_nxt = lat_cnt - LAT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = dbg_gnt ? dbg_we    : (cpu_gnt & cpu_we);
    mem_addr  = dbg_gnt ? dbg_addr  : (cpu_gnt ? cpu_addr  : '0);
    mem_wdata = dbg_gnt ? dbg_wdata : (cpu_gnt ? cpu_wdata : '0);

    rd_issue = mem_en & ~mem_we;
    rd_own   = dbg_gnt ? OWN_DBG : OWN_CPU;
    if (rd_issue) begin
      owner_nxt = rd_own;
      if (READ_LAT > 1) begin
        state_nxt = RD_WAIT;
        lat_nxt   = LAT_W'(READ_LAT - 1);
      end
    end

    if (!dbg_req || dbg_gnt)                    starve_nxt = '0;
    else if (starve_cnt != STV_W'(STARVE_LIMIT)) starve_nxt = starve_cnt + STV_W'(1);
  end

  dmem_rd_pipe #(
    .READ_LAT(READ_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .issue     (rd_issue),
    .owner     (rd_own),
    .cpu_rvalid(cpu_rvalid),
    .dbg_rvalid(dbg_rvalid)
  );

  assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : '0;

  // Stall covers both a pending un-granted request and an in-flight CPU load.
  assign cpu_stall = (cpu_req & ~cpu_gnt) | ((state == RD_WAIT) && (owner == OWN_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (READ_LAT 1, 2, 3) each with a RAM model;
// read responses go through an expected-response queue checked by a monitor.
module tb_dmem_arbiter;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NI-1:0]       cpu_req = '0, cpu_we = '0, dbg_req = '0, dbg_we = '0, pl_en = '0;
  logic [NI-1:0][7:0]  cpu_addr = '0, dbg_addr = '0;
  logic [NI-1:0][31:0] cpu_wdata = '0, dbg_wdata = '0;
  logic [NI-1:0]       cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  logic [NI-1:0][7:0]  mem_addr;
  logic [NI-1:0][31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [7:0]          pl_addr = '0;
  logic [31:0]         pl_data = '0;

  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;

  typedef struct {
    int          inst;
    int          port;
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] ram   [256];
    logic [31:0] rpipe [NI];

    dmem_arbiter #(
      .ADDR_W(8), .READ_LAT(g + 1), .STARVE_LIMIT(4)
    ) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_gnt(cpu_gnt[g]), .cpu_rvalid(cpu_rvalid[g]), .cpu_rdata(cpu_rdata[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]), .dbg_wdata(dbg_wdata[g]),
      .dbg_gnt(dbg_gnt[g]), .dbg_rvalid(dbg_rvalid[g]), .dbg_rdata(dbg_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .cpu_stall(cpu_stall[g])
    );

    // RAM model with a g+1 cycle read latency and a preload path.
    always @(posedge clk) begin
      if (pl_en[g])                    ram[pl_addr]     <= pl_data;
      else if (mem_en[g] && mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
      rpipe[0] <= ram[mem_addr[g]];
      for (int i = 1; i < NI; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata[g] = rpipe[g];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic got(input int k, input int p, input logic [31:0] d);
    exp_t e;
    if (sbq.size() == 0) begin
      n_tot++;
      $display("FAIL rsp_unexpected: inst %0d port %0d data %h at cycle %0d, expected none", k, p, d, cyc);
    end else begin
      e = sbq.pop_front();
      chk("rsp_src", k * 2 + p, e.inst * 2 + e.port);
      chk("rsp_cycle", cyc, e.cyc);
      chk("rsp_data", d, e.data);
    end
  endtask

  // Monitor: every rvalid must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        if (cpu_rvalid[k]) got(k, 0, cpu_rdata[k]);
        if (dbg_rvalid[k]) got(k, 1, dbg_rdata[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input int k, input int p, input int c, input logic [31:0] d);
    exp_t e;
    e.inst = k; e.port = p; e.cyc = c; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic preload(input int k, input logic [7:0] a, input logic [31:0] d);
    step();
    pl_en    = '0;
    pl_en[k] = 1'b1;
    pl_addr  = a;
    pl_data  = d;
  endtask

  task automatic chk_idle(input string nm, input int k);
    chk({nm, "_ctl"}, 32'({cpu_gnt[k], dbg_gnt[k], cpu_rvalid[k], dbg_rvalid[k],
                           mem_en[k], mem_we[k], cpu_stall[k]}), 32'h0);
    chk({nm, "_data"}, cpu_rdata[k] | dbg_rdata[k] | mem_wdata[k] | 32'(mem_addr[k]), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    preload(0, 8'h10, 32'hDEADBEEF);
    preload(0, 8'h11, 32'hA5A5A5A5);
    preload(1, 8'h20, 32'h0000CAFE);
    preload(2, 8'h30, 32'h12345678);
    step(); pl_en = '0;
    smp();
    for (int k = 0; k < NI; k++) chk_idle("reset", k);
    step(); rst = 1'b0;

    // CPU load alone, then a back-to-back load (READ_LAT=1)
    step(); cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'h10;
    smp();
    chkb("ld1_gnt", cpu_gnt[0], 1'b1); chkb("ld1_stall", cpu_stall[0], 1'b0);
    chk("ld1_maddr", 32'(mem_addr[0]), 32'h10); chkb("ld1_mwe", mem_we[0], 1'b0);
    push(0, 0, cyc + 1, 32'hDEADBEEF);
    step(); cpu_addr[0] = 8'h11;
    smp();
    chkb("ld2_gnt", cpu_gnt[0], 1'b1); chkb("ld2_stall", cpu_stall[0], 1'b0);
    push(0, 0, cyc + 1, 32'hA5A5A5A5);
    step(); cpu_req[0] = 1'b0;
    smp(); chkb("ld2_rsp_stall", cpu_stall[0], 1'b0);

    // Simultaneous stores: CPU first, DBG next cycle
    step();
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 8'h04; cpu_wdata[0] = 32'h11111111;
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b1; dbg_addr[0] = 8'h08; dbg_wdata[0] = 32'h22222222;
    smp();
    chkb("st_cpu_gnt", cpu_gnt[0], 1'b1); chkb("st_dbg_wait", dbg_gnt[0], 1'b0);
    chk("st_cpu_wdata", mem_wdata[0], 32'h11111111); chkb("st_cpu_mwe", mem_we[0], 1'b1);
    step(); cpu_req[0] = 1'b0;
    smp();
    chkb("st_dbg_gnt", dbg_gnt[0], 1'b1); chk("st_dbg_addr", 32'(mem_addr[0]), 32'h08);
    step(); dbg_req[0] = 1'b0;
    step(); smp();
    chk("st_ram4", g_dut[0].ram[4], 32'h11111111);
    chk("st_ram8", g_dut[0].ram[8], 32'h22222222);

    // Starvation: DBG wins on the 5th contended cycle
    step();
    cpu_req[0] = 1'b1; cpu_addr[0] = 8'h40;
    dbg_req[0] = 1'b1; dbg_addr[0] = 8'h44; dbg_wdata[0] = 32'h99;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) begin step(); cpu_wdata[0] = 32'(i); end
      smp();
      if (i < 5) begin
        chkb("stv_cpu_gnt", cpu_gnt[0], 1'b1); chkb("stv_dbg_deny", dbg_gnt[0], 1'b0);
      end else begin
        chkb("stv_dbg_gnt", dbg_gnt[0], 1'b1); chkb("stv_cpu_deny", cpu_gnt[0], 1'b0);
        chkb("stv_stall", cpu_stall[0], 1'b1);
      end
    end
    step(); smp();
    chk("stv_cnt_clr", 32'(g_dut[0].u_dut.starve_cnt), 32'h0);
    chkb("stv_cpu_back", cpu_gnt[0], 1'b1);
    step(); cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;

    // READ_LAT=3: CPU load with DBG store pending
    step();
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 8'h30;
    dbg_req[2] = 1'b1; dbg_we[2] = 1'b1; dbg_addr[2] = 8'h31; dbg_wdata[2] = 32'h55;
    smp();
    chkb("l3_gnt", cpu_gnt[2], 1'b1); chkb("l3_dbg_deny", dbg_gnt[2], 1'b0);
    push(2, 0, cyc + 3, 32'h12345678);
    step(); cpu_req[2] = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      if (i > 1) step();
      smp();
      chkb("l3_wait_en", mem_en[2], 1'b0); chkb("l3_wait_dbg", dbg_gnt[2], 1'b0);
      chkb("l3_wait_stall", cpu_stall[2], 1'b1);
    end
    step(); smp();
    chkb("l3_dbg_gnt", dbg_gnt[2], 1'b1); chk("l3_dbg_addr", 32'(mem_addr[2]), 32'h31);
    chkb("l3_rsp_stall", cpu_stall[2], 1'b0);
    step(); dbg_req[2] = 1'b0;

    // Reset while a READ_LAT=3 load is in flight
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 8'h30;
    smp(); chkb("rr_gnt", cpu_gnt[2], 1'b1);
    step(); cpu_req[2] = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    smp(); chk_idle("rr_after", 2);
    for (int i = 0; i < 5; i++) begin
      step(); smp();
      chkb("rr_no_rvalid", cpu_rvalid[2], 1'b0);
    end

    // DBG load alone, READ_LAT=2
    step(); dbg_req[1] = 1'b1; dbg_we[1] = 1'b0; dbg_addr[1] = 8'h20;
    smp();
    chkb("dl_gnt", dbg_gnt[1], 1'b1); chkb("dl_stall", cpu_stall[1], 1'b0);
    push(1, 1, cyc + 2, 32'h0000CAFE);
    step(); dbg_req[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      smp();
      chkb("dl_cpu_rvalid", cpu_rvalid[1], 1'b0);
      chk("dl_cpu_rdata", cpu_rdata[1], 32'h0);
    end

    step(); step(); smp();
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
